seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a common-anode 4-digit seven-segment display. It owns one shared hex-to-segment decoder and steps it across the digits, one refresh slot per digit. Each slot drives the active-low digit select and the decoded segment pattern. New display values arrive over a valid/ready handshake and are applied only at frame boundaries, so the display never tears. It sits between the board switch/counter logic and the HEX/anode pins.

---
 rtl/seg_pkg.sv | 29 ++
 rtl/hex_seg_lut.sv | 33 +++
 rtl/seg_scan_ctrl.sv | 130 +++++++++++++
 tb/tb_seg_scan_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan controller: active-low glyphs
// (bits 6..0 = g..a), the all-off pattern, and the slot counter width helper.
package seg_pkg;

    localparam logic [7:0] SEG_OFF   = 8'hFF;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_HEX_0 = 7'h40;
    localparam logic [6:0] SEG_HEX_1 = 7'h79;
    localparam logic [6:0] SEG_HEX_2 = 7'h24;
    localparam logic [6:0] SEG_HEX_3 = 7'h30;
    localparam logic [6:0] SEG_HEX_4 = 7'h19;
    localparam logic [6:0] SEG_HEX_5 = 7'h12;
    localparam logic [6:0] SEG_HEX_6 = 7'h02;
    localparam logic [6:0] SEG_HEX_7 = 7'h78;
    localparam logic [6:0] SEG_HEX_8 = 7'h00;
    localparam logic [6:0] SEG_HEX_9 = 7'h18;
    localparam logic [6:0] SEG_HEX_A = 7'h08;
    localparam logic [6:0] SEG_HEX_B = 7'h03;
    localparam logic [6:0] SEG_HEX_C = 7'h27;
    localparam logic [6:0] SEG_HEX_D = 7'h21;
    localparam logic [6:0] SEG_HEX_E = 7'h06;
    localparam logic [6:0] SEG_HEX_F = 7'h0E;

    function automatic int cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/hex_seg_lut.sv
// Combinational hex nibble to active-low 7-segment lookup, shared by all
// digits of the scan controller.
module hex_seg_lut
    import seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_nibble)
            4'h0: o_seg = SEG_HEX_0;
            4'h1: o_seg = SEG_HEX_1;
            4'h2: o_seg = SEG_HEX_2;
            4'h3: o_seg = SEG_HEX_3;
            4'h4: o_seg = SEG_HEX_4;
            4'h5: o_seg = SEG_HEX_5;
            4'h6: o_seg = SEG_HEX_6;
            4'h7: o_seg = SEG_HEX_7;
            4'h8: o_seg = SEG_HEX_8;
            4'h9: o_seg = SEG_HEX_9;
            4'hA: o_seg = SEG_HEX_A;
            4'hB: o_seg = SEG_HEX_B;
            4'hC: o_seg = SEG_HEX_C;
            4'hD: o_seg = SEG_HEX_D;
            4'hE: o_seg = SEG_HEX_E;
            4'hF: o_seg = SEG_HEX_F;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed common-anode display scanner with frame-synchronous value
// updates. Optional leading-zero blanking via SEG_LEADING_ZERO_BLANK_EN.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 12500,
    parameter int BLANK_CYC   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  val_valid,
    output logic                  val_ready,
    input  logic [4*DIGITS-1:0]   val_data,
    input  logic [DIGITS-1:0]     dp_mask,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     dig_sel,
    output logic                  frame_done
);

    localparam int CNT_W = cnt_width(REFRESH_DIV);
    localparam int IDX_W = $clog2(DIGITS);
    localparam logic [CNT_W-1:0] CNT_TC    = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic [4*DIGITS-1:0] r_active;
    logic [DIGITS-1:0]   r_active_dp;
    logic [4*DIGITS-1:0] r_shadow;
    logic [DIGITS-1:0]   r_shadow_dp;
    logic                r_pending;
    logic                r_ready;
    logic [7:0]          r_seg;
    logic [DIGITS-1:0]   r_dig_sel;
    logic                r_frame_done;

    logic                w_tc;
    logic                w_boundary;
    logic                w_xfer;
    logic [3:0]          w_nibble;
    logic [6:0]          w_lut;
    logic [6:0]          w_seg_lit;
    logic                w_lz_blank;
    logic [DIGITS-1:0]   w_dig_on;

    assign w_tc       = (r_cnt == CNT_TC);
    assign w_boundary = w_tc && (r_idx == IDX_LAST);
    assign w_xfer     = val_valid && r_ready;
    assign w_nibble   = r_active[{r_idx, 2'b00} +: 4];
    assign w_dig_on   = ~(DIGITS'(1) << r_idx);

    hex_seg_lut u_lut (
        .i_nibble (w_nibble),
        .o_seg    (w_lut)
    );

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // Blank when this digit and every digit above it hold zero; digit 0 always shows.
    always_comb begin
        w_lz_blank = (r_idx != '0);
        for (int j = 0; j < DIGITS; j++) begin
            if ((j >= int'(r_idx)) && (r_active[4*j +: 4] != 4'h0)) begin
                w_lz_blank = 1'b0;
            end
        end
    end
`else
    assign w_lz_blank = 1'b0;
`endif

    assign w_seg_lit = w_lz_blank ? SEG_BLANK : w_lut;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_active     <= '0;
            r_active_dp  <= '0;
            r_shadow     <= '0;
            r_shadow_dp  <= '0;
            r_pending    <= 1'b0;
            r_ready      <= 1'b1;
            r_seg        <= SEG_OFF;
            r_dig_sel    <= '1;
            r_frame_done <= 1'b0;
        end else begin
            if (w_tc) begin
                r_cnt <= '0;
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            r_frame_done <= w_boundary;

            // A pending value always blocks new transfers, so the apply and
            // bypass paths can never collide.
            if (w_boundary && r_pending) begin
                r_active    <= r_shadow;
                r_active_dp <= r_shadow_dp;
                r_pending   <= 1'b0;
                r_ready     <= 1'b1;
            end else if (w_xfer && w_boundary) begin
                r_active    <= val_data;
                r_active_dp <= dp_mask;
            end else if (w_xfer) begin
                r_shadow    <= val_data;
                r_shadow_dp <= dp_mask;
                r_pending   <= 1'b1;
                r_ready     <= 1'b0;
            end

            if (r_cnt < CNT_BLANK) begin
                r_seg     <= SEG_OFF;
                r_dig_sel <= '1;
            end else begin
                r_seg     <= {~r_active_dp[r_idx], w_seg_lit};
                r_dig_sel <= w_dig_on;
            end
        end
    end

    assign val_ready  = r_ready;
    assign seg        = r_seg;
    assign dig_sel    = r_dig_sel;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl with DIGITS=4, REFRESH_DIV=8, BLANK_CYC=2.
module tb_seg_scan_ctrl;

    localparam int DIGITS      = 4;
    localparam int REFRESH_DIV = 8;
    localparam int BLANK_CYC   = 2;
    localparam int FRAME       = DIGITS * REFRESH_DIV;

`ifdef SEG_LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        val_valid = 1'b0;
    logic        val_ready;
    logic [15:0] val_data = '0;
    logic [3:0]  dp_mask = '0;
    logic [7:0]  seg;
    logic [3:0]  dig_sel;
    logic        frame_done;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .DIGITS      (DIGITS),
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYC   (BLANK_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .val_valid  (val_valid),
        .val_ready  (val_ready),
        .val_data   (val_data),
        .dp_mask    (dp_mask),
        .seg        (seg),
        .dig_sel    (dig_sel),
        .frame_done (frame_done)
    );

    typedef struct {
        int         k;
        string      tag;
        logic [7:0] seg;
        logic [3:0] dig;
    } exp_t;

    exp_t sb_q[$];
    int   k;
    int   n_cmp;
    int   n_err;
    bit   fd_chk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, k);
        end
    endtask

    function automatic logic [7:0] lz(input logic [7:0] s);
        return LZB ? 8'hFF : s;
    endfunction

    task automatic push_at(input string tag, input int at, input logic [7:0] s, input logic [3:0] d);
        exp_t e;
        e.k   = at;
        e.tag = tag;
        e.seg = s;
        e.dig = d;
        sb_q.push_back(e);
    endtask

    // Output after edge k reflects slot state t=k-1; sample mid-slot past blanking.
    task automatic push_digit(input string tag, input int frame, input int d, input logic [7:0] s);
        logic [3:0] one;
        one = 4'b0001;
        push_at(tag, frame * FRAME + d * REFRESH_DIV + 5, s, ~(one << d));
    endtask

    task automatic step();
        @(posedge clk);
        k++;
        #1;
        if (fd_chk) chk("frame_done", frame_done, (k > 0 && (k % FRAME) == 0));
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].k == k) begin
                chk({sb_q[i].tag, "_seg"}, seg, sb_q[i].seg);
                chk({sb_q[i].tag, "_dig"}, dig_sel, sb_q[i].dig);
                sb_q.delete(i);
            end
        end
    endtask

    task automatic run_to(input int target);
        while (k < target) step();
    endtask

    task automatic offer(input logic [15:0] d, input logic [3:0] dp);
        val_data  = d;
        dp_mask   = dp;
        val_valid = 1'b1;
    endtask

    initial begin
        k = 0;
        n_cmp = 0;
        n_err = 0;
        fd_chk = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        k = 0;
        chk("rst_seg", seg, 8'hFF);
        chk("rst_dig", dig_sel, 4'hF);
        chk("rst_ready", val_ready, 1'b1);
        chk("rst_fd", frame_done, 1'b0);

        // Reset, no transfer: blank slot head then zeros.
        push_at("t1_blank_a", 1, 8'hFF, 4'hF);
        push_at("t1_blank_b", 2, 8'hFF, 4'hF);
        push_at("t1_first", 3, 8'hC0, 4'hE);
        push_digit("t1_d1", 0, 1, lz(8'hC0));
        push_digit("t1_d3", 0, 3, lz(8'hC0));
        fd_chk = 1'b1;

        // Handshake mid-frame, applied at the next boundary.
        run_to(40);
        push_digit("t2_old_d3", 1, 3, lz(8'hC0));
        push_digit("t2_d0", 2, 0, 8'h8E);
        push_digit("t2_d1", 2, 1, 8'h08);
        push_digit("t2_d2", 2, 2, 8'hA4);
        push_digit("t2_d3", 2, 3, 8'hF9);
        offer(16'h12AF, 4'b0010);
        step();
        val_valid = 1'b0;
        chk("t2_ready_fall", val_ready, 1'b0);
        run_to(63);
        chk("t2_ready_held", val_ready, 1'b0);
        run_to(64);
        chk("t2_ready_rise", val_ready, 1'b1);

        // Back-pressure: FFFF offered while not ready must be ignored.
        run_to(70);
        push_digit("t3_d0", 3, 0, 8'h82);
        push_digit("t3_d1", 3, 1, 8'h92);
        push_digit("t3_d2", 3, 2, 8'h99);
        push_digit("t3_d3", 3, 3, 8'hB0);
        offer(16'h3456, 4'b0000);
        step();
        chk("t3_ready_fall", val_ready, 1'b0);
        offer(16'hFFFF, 4'b1111);
        run_to(81);
        val_valid = 1'b0;
        chk("t3_bp_ready", val_ready, 1'b0);
        run_to(95);
        chk("t3_ready_held", val_ready, 1'b0);
        run_to(96);
        chk("t3_ready_rise", val_ready, 1'b1);

        // Bypass: transfer exactly on the boundary cycle with nothing pending.
        run_to(127);
        push_digit("t4_d0", 4, 0, 8'hF8);
        push_digit("t4_d1", 4, 1, lz(8'hC0));
        push_digit("t4_d2", 4, 2, lz(8'hC0));
        push_digit("t4_d3", 4, 3, lz(8'hC0));
        offer(16'h0007, 4'b0000);
        step();
        val_valid = 1'b0;
        chk("t4_ready_a", val_ready, 1'b1);
        step();
        chk("t4_ready_b", val_ready, 1'b1);

        // Leading-zero blanking pattern plus slot-head blanking.
        run_to(140);
        push_at("t5_blank_d0", 161, 8'hFF, 4'hF);
        push_at("t5_blank_d1", 170, 8'hFF, 4'hF);
        push_digit("t5_d0", 5, 0, 8'hC0);
        push_digit("t5_d1", 5, 1, 8'hF8);
        push_digit("t5_d2", 5, 2, lz(8'hC0));
        push_digit("t5_d3", 5, 3, lz(8'hC0));
        offer(16'h0070, 4'b0000);
        step();
        val_valid = 1'b0;
        chk("t5_ready_fall", val_ready, 1'b0);
        run_to(160);
        chk("t5_ready_rise", val_ready, 1'b1);

        // Reset during slot 2 with a value pending; the pending value is lost.
        run_to(195);
        offer(16'h89AB, 4'b1111);
        step();
        val_valid = 1'b0;
        chk("t6_pending", val_ready, 1'b0);
        run_to(210);
        chk("sb_drained_pre_rst", sb_q.size(), 0);
        fd_chk = 1'b0;
        rst = 1'b1;
        step();
        chk("t6_rst_seg", seg, 8'hFF);
        chk("t6_rst_dig", dig_sel, 4'hF);
        chk("t6_rst_ready", val_ready, 1'b1);
        chk("t6_rst_fd", frame_done, 1'b0);
        rst = 1'b0;
        k = 0;
        fd_chk = 1'b1;
        push_digit("t6_d0", 0, 0, 8'hC0);
        push_digit("t6_d1", 0, 1, lz(8'hC0));
        push_digit("t6_d2", 0, 2, lz(8'hC0));
        push_digit("t6_d3", 0, 3, lz(8'hC0));
        push_digit("t6_f1_d0", 1, 0, 8'hC0);
        push_digit("t6_f1_d3", 1, 3, lz(8'hC0));
        run_to(64);
        chk("t6_ready_after", val_ready, 1'b1);
        chk("sb_drained_end", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

endmodule
